// File: rtl/pet_input_conditioner.sv
// ---------------------------------------------------------------------------
// pet_input_conditioner
//
// Front end between the board pins and animation_controller. Every raw
// button and the touch pad is synchronized, debounced and turned into a
// one-cycle rising-edge pulse. The debounced touch level also drives a
// touch-rhythm FSM (petting), and the button pulses drive an inactivity
// timer (expecting).
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   btn_*_raw           raw buttons (center, up, down, left, right, go)
//   touch_raw           raw capacitive touch pad
//   pressed..go         one-cycle pulse on the debounced rise of each button
//   touched             debounced touch level
//   petting             high while the rhythm FSM sits in P_PET (registered)
//   expecting           high once the button-inactivity timer saturates
//   awaking             one-cycle pulse on any button or touch debounced rise
// ---------------------------------------------------------------------------

// One input lane: 2-flop synchronizer followed by a stability counter.
// The level only flips after DEB_CNT consecutive synced samples that
// disagree with it; any agreeing sample restarts the count.
module pic_debounce_lane #(
    parameter int DEB_CNT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int              CW       = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CNT - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module pet_input_conditioner #(
    parameter int DEB_CNT       = 1000000,
    parameter int PET_WINDOW    = 100000000,
    parameter int PET_TOUCHES   = 3,
    parameter int EXPECT_CYCLES = 500000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_center_raw,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_go_raw,
    input  logic touch_raw,
    output logic pressed,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic go,
    output logic touched,
    output logic petting,
    output logic expecting,
    output logic awaking
);
    localparam int NUM_LANES = 7;
    localparam int L_CENTER  = 0;
    localparam int L_UP      = 1;
    localparam int L_DOWN    = 2;
    localparam int L_LEFT    = 3;
    localparam int L_RIGHT   = 4;
    localparam int L_GO      = 5;
    localparam int L_TOUCH   = 6;

    // -----------------------------------------------------------------------
    // Input lanes
    // -----------------------------------------------------------------------
    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] level;
    logic [NUM_LANES-1:0] level_q;
    logic [NUM_LANES-1:0] rise_now;
    logic [NUM_LANES-1:0] pulse;

    assign raw = {touch_raw, btn_go_raw, btn_right_raw, btn_left_raw,
                  btn_down_raw, btn_up_raw, btn_center_raw};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        pic_debounce_lane #(
            .DEB_CNT (DEB_CNT)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[g]),
            .level (level[g])
        );
    end

    // Rising edge of the debounced level; registered so every pulse and
    // awaking line up one cycle after the level change.
    assign rise_now = level & ~level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            pulse   <= '0;
            awaking <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= rise_now;
            awaking <= |rise_now;
        end
    end

    assign pressed = pulse[L_CENTER];
    assign up      = pulse[L_UP];
    assign down    = pulse[L_DOWN];
    assign left    = pulse[L_LEFT];
    assign right   = pulse[L_RIGHT];
    assign go      = pulse[L_GO];
    assign touched = level[L_TOUCH];

    logic touch_rise;
    logic btn_pulse;

    assign touch_rise = pulse[L_TOUCH];
    assign btn_pulse  = |pulse[L_GO:L_CENTER];

    // -----------------------------------------------------------------------
    // Inactivity timer: only button pulses restart it, touch is ignored.
    // -----------------------------------------------------------------------
    localparam int            ECW     = $clog2(EXPECT_CYCLES + 1);
    localparam logic [ECW-1:0] EXP_MAX = ECW'(EXPECT_CYCLES);

    logic [ECW-1:0] exp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt <= '0;
        end else if (btn_pulse) begin
            exp_cnt <= '0;
        end else if (exp_cnt != EXP_MAX) begin
            exp_cnt <= exp_cnt + 1'b1;
        end
    end

    assign expecting = (exp_cnt == EXP_MAX);

    // -----------------------------------------------------------------------
    // Touch-rhythm FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_COUNT = 2'd1,
        P_PET   = 2'd2
    } pet_state_t;

    localparam int              TW         = $clog2(PET_WINDOW + 1);
    localparam int              NW         = $clog2(PET_TOUCHES + 1);
    localparam logic [TW-1:0]   TMR_LAST   = TW'(PET_WINDOW - 1);
    localparam logic [NW-1:0]   TOUCH_LAST = NW'(PET_TOUCHES - 1);

    pet_state_t    state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [NW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= P_IDLE;
            tmr     <= '0;
            cnt     <= '0;
            petting <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            cnt     <= cnt_nxt;
            petting <= (state == P_PET);
        end
    end

    // A rise is always checked before the timeout, so a rise landing on
    // the last window cycle keeps the state and restarts the window.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        cnt_nxt   = cnt;
        case (state)
            P_IDLE: begin
                if (touch_rise) begin
                    state_nxt = P_COUNT;
                    cnt_nxt   = NW'(1);
                    tmr_nxt   = '0;
                end
            end
            P_COUNT: begin
                if (touch_rise) begin
                    cnt_nxt = cnt + 1'b1;
                    tmr_nxt = '0;
                    if (cnt == TOUCH_LAST) state_nxt = P_PET;
                end else if (tmr == TMR_LAST) begin
                    state_nxt = P_IDLE;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            P_PET: begin
                if (touch_rise) begin
                    tmr_nxt = '0;
                end else if (tmr == TMR_LAST) begin
                    state_nxt = P_IDLE;
                    cnt_nxt   = '0;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: begin
                state_nxt = P_IDLE;
                cnt_nxt   = '0;
                tmr_nxt   = '0;
            end
        endcase
    end
endmodule

// File: doc/pet_input_conditioner.md
# pet_input_conditioner

Front-end conditioner that turns the raw board buttons and the capacitive touch pad into the clean event and level signals consumed by `animation_controller`: `pressed`, `up`, `down`, `left`, `right`, `go`, `touched`, `petting`, `expecting` and `awaking`. It synchronizes and debounces every raw input, emits one-cycle edge pulses, and runs a touch-rhythm FSM for `petting` and an inactivity timer for `expecting`. It sits between the board pins and `animation_controller`, in the same `clk` domain.

## Interface
- `DEB_CNT`, default 1000000: consecutive stable cycles required before a debounced level changes.
- `PET_WINDOW`, default 100000000: touch-rhythm window, in cycles.
- `PET_TOUCHES`, default 3: touch rises within one window needed to enter petting. Must be ≥2.
- `EXPECT_CYCLES`, default 500000000: button-inactivity cycles before `expecting` asserts.
- `clk`  in  1  system clock. This is the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `btn_center_raw`, `btn_up_raw`, `btn_down_raw`, `btn_left_raw`, `btn_right_raw`, `btn_go_raw`  in  1 each  raw buttons, active-high, asynchronous.
- `touch_raw`  in  1  raw touch pad, active-high, asynchronous.
- `pressed`, `up`, `down`, `left`, `right`, `go`  out  1 each  one-cycle pulse on the debounced rising edge of the matching button.
- `touched`  out  1  debounced touch level.
- `petting`  out  1  level, high while the petting FSM is in P_PET.
- `expecting`  out  1  level, high once the inactivity timer is saturated.
- `awaking`  out  1  one-cycle pulse on any button or touch debounced rising edge.

## Operation
- Reset (`rst_n` = 0, asynchronous): every synchronizer, debounced level, counter and output goes to 0; the FSM goes to P_IDLE.
- **Synchronizer:** each of the 7 raw inputs passes through a 2-flop synchronizer.
- **Debounce, per channel:**
  - A counter of width `$clog2(DEB_CNT+1)` clears whenever the synced value equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CNT-1 and the two still differ, the debounced level flips on the next edge and the counter clears.
- **Edge pulses:** registered, asserted for exactly 1 cycle when a debounced level goes 0→1. A falling edge produces no pulse.
- **`touched`:** equals the debounced touch level.
- **Petting FSM** (`rise` = debounced touch rising edge; `tmr` = window timer; `cnt` = rise counter):
  - P_IDLE: on `rise`, go to P_COUNT with `cnt`=1 and `tmr`=0.
  - P_COUNT, on `rise`: `cnt`++ and `tmr`=0. If `cnt`+1 == PET_TOUCHES, go to P_PET.
  - P_COUNT, no `rise`: `tmr`++. If `tmr` == PET_WINDOW-1, go to P_IDLE and clear `cnt`.
  - P_PET: `petting`=1. A `rise` clears `tmr`; otherwise `tmr`++. If `tmr` == PET_WINDOW-1 with no `rise`, go to P_IDLE.
  - A `rise` and a timeout in the same cycle: the `rise` wins (state held, `tmr`=0).
  - `petting` is the registered state decode: high the cycle after the state enters P_PET, low the cycle after it leaves.
- **Expecting timer:**
  - The counter clears on any button pulse (`pressed`/`up`/`down`/`left`/`right`/`go`). Otherwise it increments and saturates at EXPECT_CYCLES.
  - `expecting` = (counter == EXPECT_CYCLES), so it clears in the cycle after a button pulse.
  - Touch activity neither clears nor advances the timer, so `expecting` and `petting` may be high together.
- **`awaking`:** the registered OR of all 7 debounced rising edges; aligned with the edge pulses.
- Simultaneous rising edges on several channels pulse every affected output in the same cycle.

## Timing
- Raw edge to pulse output: DEB_CNT+3 cycles (2 sync + DEB_CNT debounce + 1 pulse register), for an input held stable throughout.
- Raw edge to `touched` change: DEB_CNT+2 cycles.
- A glitch shorter than DEB_CNT synced cycles produces no level change and no pulse.
- A held button produces a single pulse. A new pulse requires a debounced release followed by a new debounced press.
- `rst_n` asserted mid-debounce or mid-window aborts immediately; after release, no pulse occurs until a full DEB_CNT stable period completes.
- `rst_n` deassertion is synchronized by the integrating top level. Outputs are valid from the first edge after release.

## Test plan
Parameters for all scenarios: DEB_CNT=4, PET_WINDOW=20, PET_TOUCHES=3, EXPECT_CYCLES=50.
- **Clean press:** `btn_center_raw` 0→1 held 20 cycles → `pressed` and `awaking` high together for exactly 1 cycle, 7 cycles after the edge; no other pulse.
- **Bounce:** `btn_up_raw` toggling with a 2-cycle period for 12 cycles, then stable 1 → exactly one `up` pulse, 7 cycles after the last toggle.
- **Petting entry and exit:** 3 touch pulses (each 8 high / 6 low) → `petting`=1 after the third debounced rise. Touch then held low → `petting`=0 once 20 cycles pass with no rise.
- **Petting not reached:** 2 touch rises 25 cycles apart → `petting` never asserts; FSM returns to P_IDLE.
- **Expecting:** no button activity for 50 cycles after reset → `expecting`=1 at cycle 50 and stays. A `right` press → `expecting`=0 the cycle after the `right` pulse, then reasserts 50 cycles later. Touch pulses in between leave `expecting` unchanged.
- **Async reset mid-operation:** `rst_n`=0 during P_COUNT with `expecting`=1 → all outputs 0 immediately; after release, a held button needs the full 7 cycles to pulse.
